verificador_paridade_rom: RTL
=============================

# verificador_paridade_rom

Scan controller that sits directly downstream of the parity ROM (`rom_paridade`) and drives its address port. On a `start` request it walks an inclusive address range. It recomputes parity over each returned data word, compares it with the ROM's stored `paridade` bit, and counts mismatches. It reports the count and the address of the first mismatch to the control logic above it through a start/busy/done handshake.

## Interface
- `DATA_WIDTH`, default 8: width of ROM data word `a`.
- `ADDR_WIDTH`, default 8: width of ROM address.
- `ROM_LATENCY`, default 1: clock cycles from `addr` driven to matching `a`/`paridade` valid. Legal values are 1 and 2.
- `PARITY_ODD`, default 0: 0 means even parity (expected bit = XOR of `a`); 1 means odd parity (expected bit = inverted XOR).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a scan. Sampled only in OCIOSO.
- `addr_ini`  in  ADDR_WIDTH: first address. Latched on an accepted `start`.
- `addr_fim`  in  ADDR_WIDTH: last address, inclusive. Latched on an accepted `start`.
- `addr`  out  ADDR_WIDTH: address to the ROM.
- `a`  in  DATA_WIDTH: ROM data.
- `paridade`  in  1: ROM stored parity bit.
- `busy`  out  1: scan in progress.
- `done`  out  1: one-cycle pulse marking scan complete.
- `erro_cnt`  out  ADDR_WIDTH+1: number of mismatches.
- `erro_flag`  out  1: at least one mismatch seen.
- `primeiro_erro`  out  ADDR_WIDTH: address of the first mismatch. Holds 0 when there is none.

## Operation
- FSM states: OCIOSO, VARRE, DRENA, FIM.
- OCIOSO:
  - On `start`=1: latch `addr_ini` and `addr_fim`, set `addr` to `addr_ini`, and clear `erro_cnt`, `erro_flag` and `primeiro_erro`. Go to VARRE.
  - Otherwise the state holds and all outputs hold.
- VARRE:
  - Each cycle the current `addr` is issued, and its value plus a valid bit enter a ROM_LATENCY-deep tag pipeline.
  - If `addr` equals the latched `addr_fim`, go to DRENA. Otherwise `addr` increments modulo 2^ADDR_WIDTH.
- DRENA: wait until the tag pipeline is empty (ROM_LATENCY cycles after the last issue), then go to FIM.
- FIM: assert `done` for one cycle, then return to OCIOSO.
- Compare runs every cycle the pipeline output tag is valid:
  - Expected parity = (XOR of `a`) XOR `PARITY_ODD`.
  - On a mismatch with `paridade`: `erro_cnt` increments.
  - On the first mismatch only: `erro_flag` sets to 1 and `primeiro_erro` takes the tag address.
- Range rules:
  - Word count N = ((addr_fim − addr_ini) mod 2^ADDR_WIDTH) + 1, with 1 ≤ N ≤ 2^ADDR_WIDTH.
  - `addr_fim` < `addr_ini` wraps through the top address to 0.
  - `addr_ini` = `addr_fim` gives N = 1.
  - A full sweep requires `addr_fim` = `addr_ini` − 1.
- `erro_cnt` saturation: it cannot exceed N ≤ 2^ADDR_WIDTH, so no overflow is possible.
- `start` in any state other than OCIOSO is ignored.
- `addr_ini`/`addr_fim` changes after acceptance have no effect.
- Results hold from FIM until the next accepted `start`.

## Timing
- Reset values: state OCIOSO, `addr`=0, `busy`=0, `done`=0, `erro_cnt`=0, `erro_flag`=0, `primeiro_erro`=0, tag pipeline invalid.
- Reset mid-scan aborts immediately. No `done` is produced, and the next cycle is OCIOSO with reset values.
- Cycle 0 = the cycle in which `start` is sampled high in OCIOSO.
- Cycle 1: `addr`=`addr_ini` and `busy`=1.
- Cycle k, for 1 ≤ k ≤ N: address `addr_ini`+k−1 is issued.
- Data for the address issued in cycle k is compared in cycle k+ROM_LATENCY. Its counter update is visible from cycle k+ROM_LATENCY+1.
- `busy`=1 in cycles 1 through N+ROM_LATENCY.
- Cycle N+ROM_LATENCY+1: `busy`=0, `done`=1, and final results are valid.
- Cycle N+ROM_LATENCY+2: `done`=0. The earliest a new `start` can be accepted is this cycle.
- `start` held high continuously re-launches a scan every N+ROM_LATENCY+2 cycles.

## Test plan
- Even-parity ROM model, all words correct, `addr_ini`=0x00, `addr_fim`=0xFF, ROM_LATENCY=1 → 256 addresses issued in order 0x00..0xFF. `done` in cycle 258, `erro_cnt`=0, `erro_flag`=0, `primeiro_erro`=0.
- Same sweep with the stored parity bit flipped at 0x80 and 0x10 → `erro_cnt`=2, `erro_flag`=1, `primeiro_erro`=0x10.
- Wrap: `addr_ini`=0xFE, `addr_fim`=0x01, error injected at 0x00 → `addr` sequence FE, FF, 00, 01. `done` in cycle 6, `erro_cnt`=1, `primeiro_erro`=0x00.
- Single word: `addr_ini`=`addr_fim`=0x05, ROM_LATENCY=2 → `busy` high in cycles 1–3, `done` in cycle 4. A `start` pulse in cycle 2 is ignored (only one `done` is produced).
- `rst` asserted in cycle 50 of a full sweep → next cycle shows reset values and no `done` pulse. A fresh `start` afterwards completes normally.
- PARITY_ODD=1 with an odd-parity ROM model, data 0xFF stored with `paridade`=1 → no mismatch. A word stored with the wrong bit is counted.

Source files
------------

// File: rtl/verificador_paridade_rom.sv
// Parity ROM scan controller: walks an inclusive (wrapping) address range, re-checks
// each word's parity against the stored bit, and reports mismatch count and first address.
module verificador_paridade_rom #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int ROM_LATENCY = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_ini,
    input  logic [ADDR_WIDTH-1:0] addr_fim,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic                  paridade,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   erro_cnt,
    output logic                  erro_flag,
    output logic [ADDR_WIDTH-1:0] primeiro_erro
);

    typedef enum logic [1:0] {OCIOSO, VARRE, DRENA, FIM} estado_t;

    localparam logic IMPAR = (PARITY_ODD != 0);
    // Every stage but the output one: once these are empty, the last tag is being compared.
    localparam logic [ROM_LATENCY-1:0] MASCARA = {ROM_LATENCY{1'b1}} >> 1;

    estado_t estado, prox;

    logic [ADDR_WIDTH-1:0]  fim_q;
    logic [ADDR_WIDTH-1:0]  tag_addr [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] tag_v;
    logic                   ultimo;
    logic                   pendente;
    logic                   esperado;
    logic                   divergente;

    assign ultimo     = (addr == fim_q);
    assign pendente   = |(tag_v & MASCARA);
    assign esperado   = (^a) ^ IMPAR;
    assign divergente = tag_v[ROM_LATENCY-1] && (esperado != paridade);

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox;
    end

    always_comb begin
        prox = estado;
        busy = 1'b0;
        done = 1'b0;
        case (estado)
            OCIOSO: if (start) prox = VARRE;
            VARRE: begin
                busy = 1'b1;
                if (ultimo) prox = DRENA;
            end
            DRENA: begin
                busy = 1'b1;
                if (!pendente) prox = FIM;
            end
            FIM: begin
                done = 1'b1;
                prox = OCIOSO;
            end
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        tag_addr[0] <= addr;
        for (int unsigned i = 1; i < ROM_LATENCY; i++) tag_addr[i] <= tag_addr[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr          <= '0;
            fim_q         <= '0;
            tag_v         <= '0;
            erro_cnt      <= '0;
            erro_flag     <= 1'b0;
            primeiro_erro <= '0;
        end else begin
            tag_v[0] <= (estado == VARRE);
            for (int unsigned i = 1; i < ROM_LATENCY; i++) tag_v[i] <= tag_v[i-1];

            if (divergente) begin
                erro_cnt <= erro_cnt + 1'b1;
                if (!erro_flag) begin
                    erro_flag     <= 1'b1;
                    primeiro_erro <= tag_addr[ROM_LATENCY-1];
                end
            end

            case (estado)
                OCIOSO: if (start) begin
                    addr          <= addr_ini;
                    fim_q         <= addr_fim;
                    erro_cnt      <= '0;
                    erro_flag     <= 1'b0;
                    primeiro_erro <= '0;
                end
                VARRE: if (!ultimo) addr <= addr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
